// File: rtl/rob_pkg.sv
// Shared constants and types for the response reorder buffer.
package rob_pkg;

    localparam int ROB_ID_W   = 4;
    localparam int ROB_DATA_W = 8;
    localparam int DEPTH      = 2 ** ROB_ID_W;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        logic    wrap;
        rob_id_t idx;
    } rob_ptr_t;

endpackage

// File: rtl/rob_slot_ram.sv
// Response payload storage: one synchronous write port, one asynchronous read port, no reset.
module rob_slot_ram
    import rob_pkg::*;
#(
    parameter int DATA_W = ROB_DATA_W,
    parameter int ID_W   = ROB_ID_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ID_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ID_W-1:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ID_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rob_response_reorder.sv
// Reorder buffer: in-order ID allocation, out-of-order completion, in-order show-ahead drain.
// Optional macro ROB_BYPASS_EN forwards a head-slot response to the outputs in the same cycle.
module rob_response_reorder
    import rob_pkg::*;
#(
    parameter int DATA_W = ROB_DATA_W,
    parameter int ID_W   = ROB_ID_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [ID_W-1:0]   alloc_id_o,
    input  logic              resp_valid_i,
    input  logic [ID_W-1:0]   resp_id_i,
    input  logic [DATA_W-1:0] resp_data_i,
    output logic              out_valid_o,
    output logic [ID_W-1:0]   out_id_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              empty_o,
    output logic              full_o
);

    localparam int SLOTS = 2 ** ID_W;
    localparam logic [ID_W:0] PTR_ONE = {{ID_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic            wrap;
        logic [ID_W-1:0] idx;
    } ptr_t;

    ptr_t             alloc_ptr_q, alloc_ptr_d;
    ptr_t             head_ptr_q, head_ptr_d;
    logic [SLOTS-1:0] alloc_q, alloc_d;
    logic [SLOTS-1:0] done_q, done_d;

    logic              resp_acc;
    logic              pop;
    logic [DATA_W-1:0] ram_rdata;

    assign empty_o = (alloc_ptr_q.idx == head_ptr_q.idx) && (alloc_ptr_q.wrap == head_ptr_q.wrap);
    assign full_o  = (alloc_ptr_q.idx == head_ptr_q.idx) && (alloc_ptr_q.wrap != head_ptr_q.wrap);

    assign alloc_gnt_o = alloc_req_i & ~full_o;
    assign alloc_id_o  = alloc_ptr_q.idx;

    // Only the first response to a live ID is kept; duplicates and strays leave no trace.
    assign resp_acc = resp_valid_i & alloc_q[resp_id_i] & ~done_q[resp_id_i];

    assign out_id_o = head_ptr_q.idx;

`ifdef ROB_BYPASS_EN
    logic head_hit;
    assign head_hit    = resp_acc & (resp_id_i == head_ptr_q.idx);
    assign out_valid_o = done_q[head_ptr_q.idx] | head_hit;
    assign out_data_o  = head_hit ? resp_data_i : ram_rdata;
`else
    assign out_valid_o = done_q[head_ptr_q.idx];
    assign out_data_o  = ram_rdata;
`endif

    assign pop = out_valid_o & out_ready_i;

    rob_slot_ram #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_slot_ram (
        .clk_i   (clk_i),
        .we_i    (resp_acc),
        .waddr_i (resp_id_i),
        .wdata_i (resp_data_i),
        .raddr_i (head_ptr_q.idx),
        .rdata_o (ram_rdata)
    );

    // Completion is applied before the pop so a bypassed head that is popped ends up free.
    always_comb begin
        alloc_d     = alloc_q;
        done_d      = done_q;
        alloc_ptr_d = alloc_ptr_q;
        head_ptr_d  = head_ptr_q;

        if (resp_acc) begin
            done_d[resp_id_i] = 1'b1;
        end

        if (pop) begin
            alloc_d[head_ptr_q.idx] = 1'b0;
            done_d[head_ptr_q.idx]  = 1'b0;
            head_ptr_d              = head_ptr_q + PTR_ONE;
        end

        if (alloc_gnt_o) begin
            alloc_d[alloc_ptr_q.idx] = 1'b1;
            done_d[alloc_ptr_q.idx]  = 1'b0;
            alloc_ptr_d              = alloc_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            alloc_ptr_q <= '0;
            head_ptr_q  <= '0;
            alloc_q     <= '0;
            done_q      <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            head_ptr_q  <= head_ptr_d;
            alloc_q     <= alloc_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_rob_response_reorder.sv
// Self-checking bench for rob_response_reorder: vector table plus ordered-ID scoreboard.
module tb_rob_response_reorder;

`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       req;
    logic       gnt;
    logic [3:0] aid;
    logic       rv;
    logic [3:0] rid;
    logic [7:0] rdata;
    logic       ovalid;
    logic [3:0] oid;
    logic [7:0] odata;
    logic       rdy;
    logic       empty;
    logic       full;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  q[$];
    logic [15:0] m_alloc;
    logic [15:0] m_done;
    logic [3:0]  m_next;
    logic [7:0]  exp_data [16];

    rob_response_reorder dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .alloc_req_i  (req),
        .alloc_gnt_o  (gnt),
        .alloc_id_o   (aid),
        .resp_valid_i (rv),
        .resp_id_i    (rid),
        .resp_data_i  (rdata),
        .out_valid_o  (ovalid),
        .out_id_o     (oid),
        .out_data_o   (odata),
        .out_ready_i  (rdy),
        .empty_o      (empty),
        .full_o       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] i,
                         input logic [7:0] d, input logic y);
        req = r; rv = v; rid = i; rdata = d; rdy = y;
    endtask

    // Called with inputs settled; compares against the scoreboard then advances one clock.
    task automatic tick();
        int         sz;
        logic [3:0] hd;
        logic       acc;
        logic       ev;
        sz = q.size();
        hd = '0;
        chk("empty", empty, sz == 0);
        chk("full", full, sz == 16);
        chk("gnt", gnt, req && (sz != 16));
        chk("alloc_id", aid, m_next);
        acc = rv && m_alloc[rid] && !m_done[rid];
        ev  = 1'b0;
        if (sz != 0) begin
            hd = q[0];
            chk("out_id", oid, hd);
            ev = m_done[hd] || (BYP && acc && (rid == hd));
        end
        chk("out_valid", ovalid, ev);
        if (acc) begin
            exp_data[rid] = rdata;
            m_done[rid]   = 1'b1;
        end
        if (ev) chk("out_data", odata, exp_data[hd]);
        if (ev && rdy) begin
            void'(q.pop_front());
            m_alloc[hd] = 1'b0;
            m_done[hd]  = 1'b0;
        end
        if (req && (sz != 16)) begin
            q.push_back(m_next);
            m_alloc[m_next] = 1'b1;
            m_done[m_next]  = 1'b0;
            m_next++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] i,
                        input logic [7:0] d, input logic y);
        drive(r, v, i, d, y);
        #2;
        tick();
    endtask

    task automatic clear_model();
        q.delete();
        m_alloc = '0;
        m_done  = '0;
        m_next  = '0;
    endtask

    // Reset asserted between clock edges; effects must be visible before the next edge.
    task automatic async_reset(input string tag);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_valid"}, ovalid, 1'b0);
        chk({tag, "_out_id"}, oid, 4'd0);
        chk({tag, "_alloc_id"}, aid, 4'd0);
        chk({tag, "_gnt"}, gnt, 1'b1);
        clear_model();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    typedef struct {
        bit       req;
        bit       rv;
        bit [3:0] rid;
        bit [7:0] rd;
        bit       rdy;
        bit       e_gnt;
        bit [3:0] e_aid;
        bit       e_v;
        bit [3:0] e_oid;
        bit [7:0] e_data;
        bit       e_empty;
        bit       e_full;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1, 0, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 1, 0};
        tbl[1] = '{1, 0, 0, 8'h00, 0, 1, 1, 0,   0, 8'h00, 0, 0};
        tbl[2] = '{1, 0, 0, 8'h00, 0, 1, 2, 0,   0, 8'h00, 0, 0};
        tbl[3] = '{0, 1, 2, 8'hC2, 0, 0, 3, 0,   0, 8'h00, 0, 0};
        tbl[4] = '{0, 1, 0, 8'hA0, 0, 0, 3, BYP, 0, 8'hA0, 0, 0};
        tbl[5] = '{0, 1, 1, 8'hB1, 0, 0, 3, 1,   0, 8'hA0, 0, 0};
        tbl[6] = '{0, 0, 0, 8'h00, 1, 0, 3, 1,   0, 8'hA0, 0, 0};
        tbl[7] = '{0, 0, 0, 8'h00, 1, 0, 3, 1,   1, 8'hB1, 0, 0};
        tbl[8] = '{0, 0, 0, 8'h00, 1, 0, 3, 1,   2, 8'hC2, 0, 0};
        tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 3, 0,   3, 8'h00, 1, 0};

        rstn = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("por_empty", empty, 1'b1);
        chk("por_valid", ovalid, 1'b0);
        chk("por_full", full, 1'b0);
        rstn = 1'b1;

        // In-order drain of out-of-order responses
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].req, tbl[i].rv, tbl[i].rid, tbl[i].rd, tbl[i].rdy);
            #2;
            chk($sformatf("v%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("v%0d_aid", i), aid, tbl[i].e_aid);
            chk($sformatf("v%0d_valid", i), ovalid, tbl[i].e_v);
            chk($sformatf("v%0d_oid", i), oid, tbl[i].e_oid);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
            if (tbl[i].e_v) chk($sformatf("v%0d_data", i), odata, tbl[i].e_data);
            tick();
        end

        // Fill to full, refuse alloc even while popping, then reuse ID 0
        async_reset("rst1");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("full_flag", full, 1'b1);
        chk("full_no_gnt", gnt, 1'b0);
        tick();
        step(1'b0, 1'b1, 4'd0, 8'h50, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1);
        #2;
        chk("pop_full_no_gnt", gnt, 1'b0);
        chk("pop_full_valid", ovalid, 1'b1);
        chk("pop_full_data", odata, 8'h50);
        tick();
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("regrant", gnt, 1'b1);
        chk("regrant_id", aid, 4'd0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("wrap_full", full, 1'b1);
        chk("wrap_head", oid, 4'd1);
        tick();

        // Duplicate response keeps the first payload
        step(1'b0, 1'b1, 4'd3, 8'h33, 1'b0);
        step(1'b0, 1'b1, 4'd3, 8'h99, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i != 3) step(1'b0, 1'b1, 4'(i), 8'(i * 17), 1'b0);
        end
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
            #2;
            if (ovalid && oid == 4'd3) chk("dup_data", odata, 8'h33);
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("drain_empty", empty, 1'b1);

        // Stray response to an unallocated ID
        async_reset("rst2");
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 4'd7, 8'h77, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("stray_valid", ovalid, 1'b0);
        tick();

        // Head held under backpressure
        step(1'b0, 1'b1, 4'd0, 8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            #2;
            chk($sformatf("hold%0d_valid", k), ovalid, 1'b1);
            chk($sformatf("hold%0d_id", k), oid, 4'd0);
            chk($sformatf("hold%0d_data", k), odata, 8'h5A);
            tick();
        end
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("single_pop_id", oid, 4'd1);
        chk("single_pop_valid", ovalid, 1'b0);
        tick();

        // Head completion latency
        drive(1'b0, 1'b1, 4'd1, 8'h42, 1'b0);
        #2;
        chk("lat_same_cycle", ovalid, BYP);
        if (ovalid) chk("lat_byp_data", odata, 8'h42);
        tick();
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("lat_next_valid", ovalid, 1'b1);
        chk("lat_next_data", odata, 8'h42);
        tick();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

        // Asynchronous reset with outstanding IDs
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 4'd2, 8'h22, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("pre_rst_valid", ovalid, 1'b1);
        chk("pre_rst_empty", empty, 1'b0);
        tick();
        async_reset("rst3");
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        #2;
        chk("post_rst_gnt", gnt, 1'b1);
        chk("post_rst_id", aid, 4'd0);
        tick();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_response_reorder.md
Name: rob_response_reorder

Overview:
- Reorder buffer that hands out request IDs in order, accepts tagged responses in any order, and drains the responses in allocation order.
- Drain side is show-ahead: head data is valid on out_data_o whenever out_valid_o=1, with no read latency.
- Sits between the request issuer (allocation) and the response consumer. The consumer drains with out_valid_o/out_ready_i.

Parameters:
- DATA_W, 8, response payload width.
- ID_W, 4, ID width. Buffer depth is 2**ID_W slots; ID equals slot index.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- alloc_req_i  in  1  issuer requests a new ID.
- alloc_gnt_o  out  1  ID granted this cycle.
- alloc_id_o  out  ID_W  ID being granted; valid when alloc_gnt_o=1.
- resp_valid_i  in  1  response strobe; no backpressure.
- resp_id_i  in  ID_W  ID of the response.
- resp_data_i  in  DATA_W  response payload.
- out_valid_o  out  1  head slot holds a completed response.
- out_id_o  out  ID_W  ID of the head slot.
- out_data_o  out  DATA_W  payload of the head slot.
- out_ready_i  in  1  consumer accepts the head.
- empty_o  out  1  no IDs outstanding.
- full_o  out  1  all 2**ID_W IDs outstanding.

Behaviour:
- State:
  - alloc_ptr and head_ptr, each ID_W bits plus a wrap bit.
  - Per-slot alloc bit and done bit.
  - Storage array, not reset.
- Status flags:
  - empty_o = pointers equal and wrap bits equal.
  - full_o = pointers equal and wrap bits differ.
- Allocation:
  - alloc_gnt_o = alloc_req_i & ~full_o, combinational.
  - alloc_id_o = alloc_ptr[ID_W-1:0].
  - On grant: set alloc bit of the slot, clear its done bit, increment alloc_ptr. Natural wrap; wrap bit toggles.
- Response:
  - Accepted only if resp_valid_i, alloc bit of resp_id_i is set, and done bit is clear.
  - On accept: write resp_data_i into the slot and set its done bit.
  - Responses to unallocated or already-done IDs are dropped; no state change.
- Drain:
  - out_valid_o = done[head], registered state only; it depends on no input when ROB_BYPASS_EN is undefined.
  - out_id_o = head_ptr[ID_W-1:0].
  - out_data_o = storage[head].
  - Pop fires when out_valid_o & out_ready_i: clear the slot's alloc and done bits, increment head_ptr.
  - out_data_o is held stable while out_valid_o=1 and out_ready_i=0.
- Latency: a response accepted in cycle N to the head slot gives out_valid_o=1 in cycle N+1.
- Simultaneous events:
  - Alloc while full is refused, even if a pop fires the same cycle; no same-cycle slot reuse.
  - Alloc and pop in the same cycle are independent when not full.
  - A response and a pop in the same cycle target different slots by construction, because the head is already done.
  - A response to the slot being allocated in the same cycle is dropped, because its alloc bit is not yet set.
- Reset:
  - Asserting rstn_i at any time immediately clears pointers, wrap bits, alloc bits and done bits.
  - Resulting outputs: empty_o=1, full_o=0, out_valid_o=0, alloc_gnt_o follows alloc_req_i, out_id_o=0, alloc_id_o=0.
  - out_data_o is undefined until the first completion; benches must not check it while out_valid_o=0.
  - Outstanding IDs are lost.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined:
  - An accepted response whose ID equals the head makes out_valid_o=1 and out_data_o=resp_data_i combinationally in the same cycle.
  - Pop is permitted in that cycle. If popped, the done bit is not left set and the slot is freed.
  - This adds an input-to-output combinational path.
- Undefined: 1-cycle latency as in Behaviour; outputs depend on registers only.

Decomposition:
- Package rob_pkg: ID_W, DATA_W defaults, rob_id_t, rob_ptr_t (ID plus wrap bit), DEPTH localparam.
- Sub-module rob_slot_ram: 1 write port, 1 asynchronous read port, no reset, instantiated once.
- Alloc/done bit vectors and pointers stay in the top.

Test Plan:
- Reset, then alloc_req_i=1 for 3 cycles -> IDs 0,1,2 granted. Responses 2(0xC2), 0(0xA0), 1(0xB1), out_ready_i=1 -> drain order 0xA0, 0xB1, 0xC2 with out_id_o 0,1,2; empty_o=1 afterwards.
- Allocate 16 IDs -> full_o=1 and alloc_gnt_o=0 with alloc_req_i=1. Complete ID 0 and pop it while requesting -> no grant that cycle; grant of ID 0 next cycle, with wrap bit toggled.
- Duplicate response to ID 3 (0x33, then 0x99) -> out_data_o for ID 3 is 0x33. Response to unallocated ID 7 -> ignored; no out_valid_o change.
- Head done, out_ready_i=0 for 5 cycles -> out_valid_o, out_id_o, out_data_o stable. Then out_ready_i=1 -> single pop.
- Response to head in cycle N -> out_valid_o at N+1 without ROB_BYPASS_EN, or at N with ROB_BYPASS_EN (data equals resp_data_i).
- Assert rstn_i mid-stream with 5 outstanding IDs, asynchronously between clock edges -> empty_o=1 and out_valid_o=0 immediately. Next grant returns ID 0.
